// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch sequencer: FSM states, instruction field
// positions, jump opcode and default widths.
package cpu_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_INST_W = 11;

  localparam int OPC_MSB = 10;
  localparam int OPC_LSB = 8;
  localparam int OPR_MSB = 7;
  localparam int OPR_LSB = 0;

  localparam logic [2:0] OPC_JMP = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC
  } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer and its program memory / IR / datapath.
// The master side is the sequencer.
interface fetch_sequencer_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INST_W = DEF_INST_W
) ();

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [INST_W-1:0] mem_rdata;
  logic [INST_W-1:0] inst;
  logic              decode;
  logic              exec_en;
  logic              exec_done;

  modport master (
    output mem_req, mem_addr, inst, decode, exec_en,
    input  mem_ack, mem_rdata, exec_done
  );

  modport slave (
    input  mem_req, mem_addr, inst, decode, exec_en,
    output mem_ack, mem_rdata, exec_done
  );

endinterface

// File: rtl/pc_counter.sv
// Program counter register: async reset to RESET_PC, load beats increment,
// increment wraps modulo 2^ADDR_W.
module pc_counter
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_en,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load_en) begin
      pc <= load_val;
    end else if (inc_en) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch / decode / execute sequencer feeding the IR and datapath.
// Optional macro JUMP_EN makes ALU select 3'b111 load the PC from the operand.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INST_W   = DEF_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  fetch_sequencer_if.master bus,
  output logic [ADDR_W-1:0] pc,
  output logic              busy
);

  state_t            state, state_nxt;
  logic [INST_W-1:0] inst_r;
  logic              mem_req_r;
  logic              decode_r;
  logic              exec_en_r;
  logic              inc_en;
  logic              load_en;
  logic              is_jump;
  logic [ADDR_W-1:0] load_val;

`ifdef JUMP_EN
  assign is_jump = (inst_r[OPC_MSB:OPC_LSB] == OPC_JMP);
`else
  assign is_jump = 1'b0;
`endif

  assign load_val = ADDR_W'(inst_r[OPR_MSB:OPR_LSB]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // run only matters in IDLE and when EXEC finishes, so an instruction in
  // flight always completes.
  always_comb begin
    state_nxt = state;
    inc_en    = 1'b0;
    load_en   = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_nxt = FETCH;
      end
      FETCH: begin
        if (bus.mem_ack) state_nxt = DECODE;
      end
      DECODE: begin
        state_nxt = EXEC;
      end
      EXEC: begin
        if (bus.exec_done) begin
          load_en   = is_jump;
          inc_en    = !is_jump;
          state_nxt = run ? FETCH : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe without a combinational path to the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_r    <= '0;
      mem_req_r <= 1'b0;
      decode_r  <= 1'b0;
      exec_en_r <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (state == FETCH && bus.mem_ack) inst_r <= bus.mem_rdata;
      mem_req_r <= (state_nxt == FETCH);
      decode_r  <= (state_nxt == DECODE);
      exec_en_r <= (state_nxt == EXEC);
      busy      <= (state_nxt != IDLE);
    end
  end

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_en   (inc_en),
    .load_en  (load_en),
    .load_val (load_val),
    .pc       (pc)
  );

  assign bus.mem_req  = mem_req_r;
  assign bus.mem_addr = pc;
  assign bus.inst     = inst_r;
  assign bus.decode   = decode_r;
  assign bus.exec_en  = exec_en_r;

endmodule
